// File: rtl/aq_iu_div_pkg.sv
// aq_iu_div_pkg: shared types and helpers for the IU divider control.
// State encodings, func bit indices and operand helpers.
package aq_iu_div_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP0 = 3'd1,
    ST_PREP1 = 3'd2,
    ST_ALIGN = 3'd3,
    ST_ITER  = 3'd4,
    ST_DONE  = 3'd5
  } div_state_e;

  localparam int FN_SIGNED = 0;
  localparam int FN_REM    = 1;
  localparam int FN_WORD   = 2;

  localparam logic [XLEN-1:0] MIN64 =
    64'h8000_0000_0000_0000;
  // 32-bit minimum as it appears after sign extension
  localparam logic [XLEN-1:0] MIN32 =
    64'hFFFF_FFFF_8000_0000;

  function automatic logic [XLEN-1:0] op_ext(
    input logic [XLEN-1:0] src,
    input logic [2:0]      func
  );
    if (!func[FN_WORD]) return src;
    return {{32{func[FN_SIGNED] & src[31]}},
            src[31:0]};
  endfunction

  function automatic logic [XLEN-1:0] op_abs(
    input logic [XLEN-1:0] v,
    input logic            sgn
  );
    if (sgn && v[XLEN-1]) return ~v + 64'd1;
    return v;
  endfunction

endpackage

// File: rtl/aq_iu_div_if.sv
// aq_iu_div_if: EX request / writeback result bundle
// between the integer pipe and the divider.
interface aq_iu_div_if;
  import aq_iu_div_pkg::*;

  logic            ex_div_sel;
  logic [XLEN-1:0] ex_div_src0;
  logic [XLEN-1:0] ex_div_src1;
  logic [2:0]      ex_div_func;
  logic            rtu_iu_flush;
  logic            iu_div_result_ack;
  logic            div_iu_busy;
  logic            div_iu_result_vld;
  logic [XLEN-1:0] div_iu_result;

  modport master (
    output ex_div_sel,
    output ex_div_src0,
    output ex_div_src1,
    output ex_div_func,
    output rtu_iu_flush,
    output iu_div_result_ack,
    input  div_iu_busy,
    input  div_iu_result_vld,
    input  div_iu_result
  );

  modport slave (
    input  ex_div_sel,
    input  ex_div_src0,
    input  ex_div_src1,
    input  ex_div_func,
    input  rtu_iu_flush,
    input  iu_div_result_ack,
    output div_iu_busy,
    output div_iu_result_vld,
    output div_iu_result
  );

endinterface

// File: rtl/aq_iu_div_ff1.sv
// aq_iu_div_ff1: 64-bit leading-one detector.
// Returns the index of the MS set bit, 0 for a zero operand.
module aq_iu_div_ff1
  import aq_iu_div_pkg::*;
(
  input  logic [XLEN-1:0] op,
  output logic [5:0]      idx
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (op[i]) idx = 6'(i);
    end
  end

endmodule

// File: rtl/aq_iu_div_ctrl.sv
// aq_iu_div_ctrl: divider control, operand pre/post-processing
// and writeback handshake in front of the 2-bit shift kernel.
module aq_iu_div_ctrl
  import aq_iu_div_pkg::*;
(
  input  logic            div_clk,
  input  logic            cpurst_b,
  aq_iu_div_if.slave      ex,
  input  logic            div_iter_cmplt,
  input  logic [XLEN-1:0] div_quotient_reg_updt,
  input  logic [XLEN-1:0] div_remainder_reg_updt,
  input  logic [XLEN-1:0] div_divisor_update_data,
  output logic            div_prepare_src0,
  output logic            div_prepare_src1,
  output logic            div_align,
  output logic            div_iterating,
  output logic [5:0]      div_ff1_res,
  output logic [XLEN-1:0] div_quotient_reg,
  output logic [XLEN-1:0] div_remainder_reg,
  output logic [XLEN-1:0] div_divisor_reg
);

  div_state_e      state;
  logic [2:0]      func_q;
  logic [XLEN-1:0] src0_q;
  logic [XLEN-1:0] src1_q;
  logic            dbz_q;
  logic            ovf_q;
  logic            fin_q;
  logic            vld_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] src0_x;
  logic [XLEN-1:0] src1_x;
  logic            dbz;
  logic            ovf;
  logic            sgn;
  logic [XLEN-1:0] abs0;
  logic [XLEN-1:0] abs1;
  logic [5:0]      ff1_idx;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] q_fin;
  logic [XLEN-1:0] r_fin;
  logic [XLEN-1:0] pick;
  logic [XLEN-1:0] final_res;

  assign div_prepare_src0 = (state == ST_PREP0);
  assign div_prepare_src1 = (state == ST_PREP1);
  assign div_align        = (state == ST_ALIGN);
  assign div_iterating    = (state == ST_ITER);

  assign ex.div_iu_busy       = (state != ST_IDLE);
  assign ex.div_iu_result_vld = vld_q;
  assign ex.div_iu_result     = result_q;

  always_comb begin
    src0_x = op_ext(ex.ex_div_src0, ex.ex_div_func);
    src1_x = op_ext(ex.ex_div_src1, ex.ex_div_func);
    dbz    = (src1_x == '0);
    ovf    = ex.ex_div_func[FN_SIGNED]
           && (src0_x == (ex.ex_div_func[FN_WORD]
                          ? MIN32 : MIN64))
           && (src1_x == '1);
  end

  assign sgn  = func_q[FN_SIGNED];
  assign abs0 = op_abs(src0_q, sgn);
  assign abs1 = op_abs(src1_q, sgn);

  aq_iu_div_ff1 u_ff1 (
    .op  (div_prepare_src1 ? abs1 : abs0),
    .idx (ff1_idx)
  );

  assign div_ff1_res =
    (div_prepare_src0 || div_prepare_src1)
      ? ff1_idx : 6'd0;

  always_comb begin
    neg_q = sgn && (src0_q[XLEN-1] ^ src1_q[XLEN-1]);
    neg_r = sgn && src0_q[XLEN-1];
    unique case (1'b1)
      dbz_q: begin
        q_fin = '1;
        r_fin = src0_q;
      end
      ovf_q: begin
        q_fin = src0_q;
        r_fin = '0;
      end
      default: begin
        q_fin = neg_q ? ~div_quotient_reg + 64'd1
                      : div_quotient_reg;
        r_fin = neg_r ? ~div_remainder_reg + 64'd1
                      : div_remainder_reg;
      end
    endcase
    pick      = func_q[FN_REM] ? r_fin : q_fin;
    final_res = func_q[FN_WORD]
              ? {{32{pick[31]}}, pick[31:0]}
              : pick;
  end

  always_ff @(posedge div_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state             <= ST_IDLE;
      func_q            <= '0;
      src0_q            <= '0;
      src1_q            <= '0;
      dbz_q             <= 1'b0;
      ovf_q             <= 1'b0;
      fin_q             <= 1'b0;
      vld_q             <= 1'b0;
      result_q          <= '0;
      div_quotient_reg  <= '0;
      div_remainder_reg <= '0;
      div_divisor_reg   <= '0;
    end else if (state != ST_IDLE && ex.rtu_iu_flush) begin
      state <= ST_IDLE;
      fin_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (ex.ex_div_sel && !ex.rtu_iu_flush) begin
            func_q <= ex.ex_div_func;
            src0_q <= src0_x;
            src1_q <= src1_x;
            dbz_q  <= dbz;
            ovf_q  <= ovf;
            fin_q  <= dbz || ovf;
            state  <= (dbz || ovf) ? ST_DONE : ST_PREP0;
          end
        end
        ST_PREP0: begin
          div_remainder_reg <= abs0;
          state             <= ST_PREP1;
        end
        ST_PREP1: begin
          div_divisor_reg <= abs1;
          state           <= ST_ALIGN;
        end
        ST_ALIGN: begin
          div_divisor_reg  <= div_divisor_update_data;
          div_quotient_reg <= '0;
          state            <= ST_ITER;
        end
        ST_ITER: begin
          div_quotient_reg  <= div_quotient_reg_updt;
          div_remainder_reg <= div_remainder_reg_updt;
          div_divisor_reg   <= div_divisor_update_data;
          if (div_iter_cmplt) begin
            fin_q <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (fin_q) begin
            result_q <= final_res;
            vld_q    <= 1'b1;
            fin_q    <= 1'b0;
          end else if (vld_q && ex.iu_div_result_ack) begin
            vld_q <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
